// File: rtl/wb_sequencer.sv
// Writeback sequencer for the multicycle MIPS core: follows one instruction from issue to its
// single register-file write, driving the mem / link / ALU writeback mux selects.
module wb_sequencer #(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned LINK_REG    = 31,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             issue_valid,
    output logic             issue_ready,
    input  logic             issue_isLd,
    input  logic             issue_isCall,
    input  logic             issue_wr,
    input  logic [4:0]       issue_rd,
    input  logic             alu_done,
    input  logic             mem_rdy,
    input  logic             flush,
    output logic             isLd,
    output logic             isCall,
    output logic             rf_we,
    output logic [4:0]       rf_waddr,
    output logic             mem_timeout,
    output logic             err_sel,
    output logic [CNT_W-1:0] retired
);

    localparam int unsigned   TW     = $clog2(MEM_TIMEOUT);
    localparam logic [TW-1:0] T_LAST = TW'(MEM_TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        MEM_WAIT,
        WB
    } state_t;

    state_t           state_q, state_d;
    logic             isLd_q, isLd_d;
    logic             isCall_q, isCall_d;
    logic             wr_q, wr_d;
    logic [4:0]       waddr_q, waddr_d;
    logic [TW-1:0]    tcnt_q, tcnt_d;
    logic             mem_timeout_q, mem_timeout_d;
    logic             err_sel_q, err_sel_d;
    logic [CNT_W-1:0] retired_q, retired_d;

    always_comb begin
        state_d       = state_q;
        isLd_d        = isLd_q;
        isCall_d      = isCall_q;
        wr_d          = wr_q;
        waddr_d       = waddr_q;
        tcnt_d        = tcnt_q;
        retired_d     = retired_q;
        mem_timeout_d = 1'b0;
        err_sel_d     = 1'b0;
        rf_we         = (state_q == WB) && wr_q && !flush;

        case (state_q)
            IDLE: begin
                if (issue_valid) begin
                    // A call wins over a load when decode flags both.
                    isCall_d  = issue_isCall;
                    isLd_d    = issue_isLd & ~issue_isCall;
                    err_sel_d = issue_isLd & issue_isCall;
                    wr_d      = issue_isCall | (issue_wr & (issue_rd != 5'd0));
                    waddr_d   = issue_isCall ? 5'(LINK_REG) : issue_rd;
                    tcnt_d    = '0;
                    if (issue_isCall) begin
                        state_d = WB;
                    end else if (issue_isLd) begin
                        state_d = MEM_WAIT;
                    end else begin
                        state_d = EXEC;
                    end
                end
            end
            EXEC: begin
                if (flush) begin
                    state_d = IDLE;
                end else if (alu_done) begin
                    state_d = WB;
                end
            end
            MEM_WAIT: begin
                if (flush) begin
                    state_d = IDLE;
                end else if (mem_rdy) begin
                    state_d = WB;
                end else if (tcnt_q == T_LAST) begin
                    state_d       = IDLE;
                    mem_timeout_d = 1'b1;
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
            WB: begin
                state_d = IDLE;
                if (rf_we) begin
                    retired_d = retired_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (state_d == IDLE) begin
            isLd_d   = 1'b0;
            isCall_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            isLd_q        <= 1'b0;
            isCall_q      <= 1'b0;
            wr_q          <= 1'b0;
            waddr_q       <= '0;
            tcnt_q        <= '0;
            mem_timeout_q <= 1'b0;
            err_sel_q     <= 1'b0;
            retired_q     <= '0;
        end else begin
            state_q       <= state_d;
            isLd_q        <= isLd_d;
            isCall_q      <= isCall_d;
            wr_q          <= wr_d;
            waddr_q       <= waddr_d;
            tcnt_q        <= tcnt_d;
            mem_timeout_q <= mem_timeout_d;
            err_sel_q     <= err_sel_d;
            retired_q     <= retired_d;
        end
    end

    assign issue_ready = (state_q == IDLE);
    assign isLd        = isLd_q;
    assign isCall      = isCall_q;
    assign rf_waddr    = waddr_q;
    assign mem_timeout = mem_timeout_q;
    assign err_sel     = err_sel_q;
    assign retired     = retired_q;

endmodule

// File: tb/tb_wb_sequencer.sv
// Self-checking bench for wb_sequencer: vector table of single instructions plus hand-written
// flush / timeout / reset sequences; register-file writes are matched against a scoreboard queue.
module tb_wb_sequencer;

    localparam int unsigned MT = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        issue_valid;
    logic        issue_ready;
    logic        issue_isLd;
    logic        issue_isCall;
    logic        issue_wr;
    logic [4:0]  issue_rd;
    logic        alu_done;
    logic        mem_rdy;
    logic        flush;
    logic        isLd;
    logic        isCall;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic        mem_timeout;
    logic        err_sel;
    logic [15:0] retired;

    wb_sequencer #(
        .MEM_TIMEOUT(MT),
        .LINK_REG   (31),
        .CNT_W      (16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .issue_valid (issue_valid),
        .issue_ready (issue_ready),
        .issue_isLd  (issue_isLd),
        .issue_isCall(issue_isCall),
        .issue_wr    (issue_wr),
        .issue_rd    (issue_rd),
        .alu_done    (alu_done),
        .mem_rdy     (mem_rdy),
        .flush       (flush),
        .isLd        (isLd),
        .isCall      (isCall),
        .rf_we       (rf_we),
        .rf_waddr    (rf_waddr),
        .mem_timeout (mem_timeout),
        .err_sel     (err_sel),
        .retired     (retired)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       ld;
        logic       call;
        logic       wr;
        logic [4:0] rd;
        int         dly;
        logic       exp_we;
        logic [4:0] exp_addr;
        logic       exp_ld;
        logic       exp_call;
        logic       exp_err;
    } vec_t;

    vec_t        vecs[9];
    int          checks = 0;
    int          errors = 0;
    logic [4:0]  sb_q[$];
    logic [15:0] exp_ret;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Every register-file write must match the oldest expected write.
    always @(negedge clk) begin
        if (rf_we === 1'b1) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected_write actual waddr=%0d expected no write", rf_waddr);
            end else begin
                chk("sb_waddr", 32'(rf_waddr), 32'(sb_q.pop_front()));
            end
        end
    end

    task automatic issue(input logic ld, input logic call, input logic wr, input logic [4:0] rd);
        int n = 0;
        while (issue_ready !== 1'b1 && n < 32) begin
            tick();
            n++;
        end
        chk("issue_ready_wait", 32'(issue_ready), 32'd1);
        issue_isLd   = ld;
        issue_isCall = call;
        issue_wr     = wr;
        issue_rd     = rd;
        issue_valid  = 1'b1;
        tick();
        issue_valid  = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        issue(v.ld, v.call, v.wr, v.rd);
        if (v.exp_we) sb_q.push_back(v.exp_addr);
        if (!v.call) begin
            for (int k = 1; k <= v.dly; k++) begin
                if (k == v.dly) begin
                    if (v.ld) mem_rdy = 1'b1;
                    else      alu_done = 1'b1;
                end
                @(negedge clk);
                if (k == 1) chk("err_sel", 32'(err_sel), 32'(v.exp_err));
                chk("wait_we", 32'(rf_we), 32'd0);
                chk("wait_ready", 32'(issue_ready), 32'd0);
                chk("wait_isLd", 32'(isLd), 32'(v.exp_ld));
                chk("wait_isCall", 32'(isCall), 32'(v.exp_call));
                chk("wait_waddr", 32'(rf_waddr), 32'(v.exp_addr));
                tick();
                mem_rdy  = 1'b0;
                alu_done = 1'b0;
            end
        end
        @(negedge clk);
        if (v.call) chk("err_sel", 32'(err_sel), 32'(v.exp_err));
        chk("wb_we", 32'(rf_we), 32'(v.exp_we));
        chk("wb_waddr", 32'(rf_waddr), 32'(v.exp_addr));
        chk("wb_isLd", 32'(isLd), 32'(v.exp_ld));
        chk("wb_isCall", 32'(isCall), 32'(v.exp_call));
        if (v.exp_we) exp_ret = exp_ret + 16'd1;
        tick();
        chk("post_ready", 32'(issue_ready), 32'd1);
        chk("post_isLd", 32'(isLd), 32'd0);
        chk("post_isCall", 32'(isCall), 32'd0);
        chk("post_err_sel", 32'(err_sel), 32'd0);
        chk("post_retired", 32'(retired), 32'(exp_ret));
    endtask

    initial begin
        // ld call wr rd dly | we addr isLd isCall err
        vecs[0] = '{1'b0, 1'b0, 1'b1, 5'd5,  3,  1'b1, 5'd5,  1'b0, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 1'b1, 1'b1, 5'd7,  0,  1'b1, 5'd31, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{1'b1, 1'b0, 1'b1, 5'd9,  4,  1'b1, 5'd9,  1'b1, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 1'b1, 1'b1, 5'd12, 0,  1'b1, 5'd31, 1'b0, 1'b1, 1'b1};
        vecs[4] = '{1'b0, 1'b0, 1'b1, 5'd0,  1,  1'b0, 5'd0,  1'b0, 1'b0, 1'b0};
        vecs[5] = '{1'b0, 1'b0, 1'b0, 5'd3,  2,  1'b0, 5'd3,  1'b0, 1'b0, 1'b0};
        vecs[6] = '{1'b1, 1'b0, 1'b1, 5'd0,  1,  1'b0, 5'd0,  1'b1, 1'b0, 1'b0};
        vecs[7] = '{1'b1, 1'b0, 1'b1, 5'd20, 16, 1'b1, 5'd20, 1'b1, 1'b0, 1'b0};
        vecs[8] = '{1'b0, 1'b1, 1'b0, 5'd0,  0,  1'b1, 5'd31, 1'b0, 1'b1, 1'b0};

        reset        = 1'b1;
        issue_valid  = 1'b0;
        issue_isLd   = 1'b0;
        issue_isCall = 1'b0;
        issue_wr     = 1'b0;
        issue_rd     = 5'd0;
        alu_done     = 1'b0;
        mem_rdy      = 1'b0;
        flush        = 1'b0;
        exp_ret      = 16'd0;

        @(negedge clk);
        chk("rst_ready", 32'(issue_ready), 32'd1);
        chk("rst_isLd", 32'(isLd), 32'd0);
        chk("rst_isCall", 32'(isCall), 32'd0);
        chk("rst_we", 32'(rf_we), 32'd0);
        chk("rst_waddr", 32'(rf_waddr), 32'd0);
        chk("rst_timeout", 32'(mem_timeout), 32'd0);
        chk("rst_err_sel", 32'(err_sel), 32'd0);
        chk("rst_retired", 32'(retired), 32'd0);
        tick();
        reset = 1'b0;
        tick();

        foreach (vecs[i]) run_vec(vecs[i]);

        // Strobes in IDLE without an issue must be ignored.
        alu_done = 1'b1;
        mem_rdy  = 1'b1;
        flush    = 1'b1;
        tick();
        alu_done = 1'b0;
        mem_rdy  = 1'b0;
        flush    = 1'b0;
        @(negedge clk);
        chk("idle_strobe_ready", 32'(issue_ready), 32'd1);
        chk("idle_strobe_retired", 32'(retired), 32'(exp_ret));
        tick();

        // Load with no mem_rdy: timeout pulse exactly one cycle after MT waiting cycles.
        issue(1'b1, 1'b0, 1'b1, 5'd10);
        for (int k = 1; k <= int'(MT); k++) begin
            @(negedge clk);
            chk("to_we", 32'(rf_we), 32'd0);
            chk("to_early_pulse", 32'(mem_timeout), 32'd0);
            chk("to_busy", 32'(issue_ready), 32'd0);
            chk("to_isLd", 32'(isLd), 32'd1);
            tick();
        end
        @(negedge clk);
        chk("to_pulse", 32'(mem_timeout), 32'd1);
        chk("to_ready", 32'(issue_ready), 32'd1);
        chk("to_isLd_clr", 32'(isLd), 32'd0);
        chk("to_retired", 32'(retired), 32'(exp_ret));
        tick();
        @(negedge clk);
        chk("to_pulse_end", 32'(mem_timeout), 32'd0);
        tick();

        // Flush in EXEC beats a simultaneous alu_done.
        issue(1'b0, 1'b0, 1'b1, 5'd4);
        flush    = 1'b1;
        alu_done = 1'b1;
        tick();
        flush    = 1'b0;
        alu_done = 1'b0;
        chk("fl_exec_ready", 32'(issue_ready), 32'd1);
        @(negedge clk);
        chk("fl_exec_we", 32'(rf_we), 32'd0);
        chk("fl_exec_retired", 32'(retired), 32'(exp_ret));
        tick();

        // Flush during WB suppresses the write.
        issue(1'b0, 1'b1, 1'b1, 5'd1);
        flush = 1'b1;
        @(negedge clk);
        chk("fl_wb_we", 32'(rf_we), 32'd0);
        chk("fl_wb_isCall", 32'(isCall), 32'd1);
        tick();
        flush = 1'b0;
        chk("fl_wb_ready", 32'(issue_ready), 32'd1);
        chk("fl_wb_retired", 32'(retired), 32'(exp_ret));
        chk("fl_wb_isCall_clr", 32'(isCall), 32'd0);

        // Flush together with an issue in IDLE does not block acceptance.
        flush = 1'b1;
        issue(1'b0, 1'b0, 1'b1, 5'd6);
        flush = 1'b0;
        chk("fl_idle_accept", 32'(issue_ready), 32'd0);
        sb_q.push_back(5'd6);
        exp_ret  = exp_ret + 16'd1;
        alu_done = 1'b1;
        tick();
        alu_done = 1'b0;
        @(negedge clk);
        chk("fl_idle_we", 32'(rf_we), 32'd1);
        chk("fl_idle_waddr", 32'(rf_waddr), 32'd6);
        tick();
        chk("fl_idle_retired", 32'(retired), 32'(exp_ret));

        // Asynchronous reset while waiting on memory drops the pending write.
        issue(1'b1, 1'b0, 1'b1, 5'd11);
        tick();
        tick();
        reset = 1'b1;
        #1;
        exp_ret = 16'd0;
        chk("rst_mid_ready", 32'(issue_ready), 32'd1);
        chk("rst_mid_isLd", 32'(isLd), 32'd0);
        chk("rst_mid_waddr", 32'(rf_waddr), 32'd0);
        chk("rst_mid_retired", 32'(retired), 32'd0);
        mem_rdy = 1'b1;
        tick();
        reset   = 1'b0;
        mem_rdy = 1'b0;
        tick();
        chk("rst_mid_idle", 32'(issue_ready), 32'd1);
        run_vec(vecs[0]);

        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
